// File: rtl/mul_pkg.sv
// ============================================================================
// Module      : mul_pkg
// Description : Shared state encoding and step constants for seq_multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    localparam int MUL_STEPS = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_multiplier_if.sv
// ============================================================================
// Module      : seq_multiplier_if
// Description : Request/result bundle between ALU control and the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_multiplier_if;

    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        ovf;

    modport master (
        output start, a, b,
        input  busy, done, product, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, ovf
    );

endinterface

`default_nettype wire

// File: rtl/yAdder.sv
// ============================================================================
// Module      : yAdder
// Description : 32-bit combinational ripple-carry adder with carry in/out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module yAdder (
    input  wire logic [31:0] a,
    input  wire logic [31:0] b,
    input  wire logic        cin,
    output logic [31:0]      z,
    output logic             cout
);

    logic [32:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar i = 0; i < 32; i++) begin : g_bit
            assign z[i]       = a[i] ^ b[i] ^ carry[i];
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = carry[32];

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module      : seq_multiplier
// Description : 32x32 unsigned shift-and-add multiplier, one add per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier
    import mul_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    seq_multiplier_if.slave   bus
);

    logic [31:0]      mcand;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [CNT_W-1:0] cnt;
    state_t           state;
    logic             busy_reg;
    logic             done_reg;

    logic [31:0]      sum;
    logic             carry_out;
    logic             accept;

    yAdder u_adder (
        .a    (hi),
        .b    (mcand),
        .cin  (1'b0),
        .z    (sum),
        .cout (carry_out)
    );

    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= '0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (accept) begin
                        mcand    <= bus.a;
                        hi       <= '0;
                        lo       <= bus.b;
                        cnt      <= '0;
                        busy_reg <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    // Adder carry becomes the new top bit of hi so no sum bit is lost.
                    if (lo[0]) begin
                        {hi, lo} <= {carry_out, sum, lo[31:1]};
                    end else begin
                        {hi, lo} <= {1'b0, hi, lo[31:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(MUL_STEPS - 1)) begin
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.product = {hi, lo};
    assign bus.ovf     = |hi;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Directed vector table plus corner sequences for seq_multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_multiplier;

    logic clk;
    logic rst;

    seq_multiplier_if bus ();

    seq_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int passed;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Waits for done, sampling on falling edges; returns cycles since accept and busy count.
    task automatic wait_done(input int first_j, output int lat, output int busy_cnt);
        int j;
        lat      = -1;
        busy_cnt = 0;
        j        = first_j;
        while (j <= 40 && lat < 0) begin
            if (bus.busy && bus.done) check("busy_done_overlap", 64'd1, 64'd0);
            if (bus.done) lat = j;
            else if (bus.busy) busy_cnt++;
            if (lat < 0) begin
                @(negedge clk);
                j++;
            end
        end
        if (lat < 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_job(input vec_t v, input string name);
        int lat, bc;
        @(negedge clk);
        bus.a     = v.a;
        bus.b     = v.b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~v.a;
        bus.b     = ~v.b;
        check({name, "_cleared"}, bus.product, {32'h0, v.b});
        wait_done(1, lat, bc);
        check({name, "_latency"}, 64'(lat), 64'd33);
        check({name, "_busy_cycles"}, 64'(bc), 64'd32);
        check({name, "_product"}, bus.product, v.prod);
        check({name, "_ovf"}, 64'(bus.ovf), 64'(v.ovf));
        @(negedge clk);
        check({name, "_done_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
        check({name, "_held"}, bus.product, v.prod);
    endtask

    vec_t vecs [8];

    initial begin
        int lat, bc, seen;
        total     = 0;
        passed    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0] = '{32'd3,         32'd5,         64'h0F,                  1'b0};
        vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001,   1'b1};
        vecs[2] = '{32'h0,         32'h12345678,  64'h0,                   1'b0};
        vecs[3] = '{32'h12345678,  32'h0,         64'h0,                   1'b0};
        vecs[4] = '{32'd7,         32'd9,         64'h3F,                  1'b0};
        vecs[5] = '{32'h10000,     32'h10000,     64'h1_00000000,          1'b1};
        vecs[6] = '{32'h80000000,  32'h80000000,  64'h40000000_00000000,   1'b1};
        vecs[7] = '{32'h12345678,  32'd9,         64'hA3D70A38,            1'b0};

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_product", bus.product, 64'h0);
        check("reset_ovf", 64'(bus.ovf), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.a = 32'd99; bus.b = 32'd99; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(11, lat, bc);
        check("ignore_latency", 64'(lat), 64'd33);
        check("ignore_product", bus.product, 64'h0F);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("ignore_no_second_job", 64'(seen), 64'd0);

        // reset in the middle of a job
        @(negedge clk);
        bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_pre_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_product", bus.product, 64'h0);
        run_job('{32'hFFFFFFFF, 32'd2, 64'h1_FFFFFFFE, 1'b1}, "after_rst");

        // back-to-back with start held high
        @(negedge clk);
        bus.a = 32'd7; bus.b = 32'd9; bus.start = 1'b1;
        @(negedge clk);
        bus.a = 32'h10000; bus.b = 32'h10000;
        wait_done(1, lat, bc);
        check("b2b_first_latency", 64'(lat), 64'd33);
        check("b2b_first_product", bus.product, 64'h3F);
        check("b2b_first_ovf", 64'(bus.ovf), 64'd0);
        @(negedge clk);
        check("b2b_no_bubble", 64'({bus.busy, bus.done}), 64'b10);
        check("b2b_second_cleared", bus.product, 64'h0000_0000_0001_0000);
        wait_done(1, lat, bc);
        bus.start = 1'b0;
        check("b2b_second_latency", 64'(lat), 64'd33);
        check("b2b_second_product", bus.product, 64'h1_00000000);
        check("b2b_second_ovf", 64'(bus.ovf), 64'd1);
        @(negedge clk);
        check("b2b_idle", 64'({bus.busy, bus.done}), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
